// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: song word layout, special codes
// and FSM state encodings.
package note_sequencer_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NOTE_W     = 5;
  localparam int unsigned DUR_W      = 3;

  localparam int unsigned NOTE_MSB = 7;
  localparam int unsigned NOTE_LSB = 3;
  localparam int unsigned DUR_MSB  = 2;
  localparam int unsigned DUR_LSB  = 0;

  localparam logic [NOTE_W-1:0] REST_CODE = 5'd0;
  localparam logic [NOTE_W-1:0] END_CODE  = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REWIND,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module beat_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song playback sequencer: fetches words from memory, plays each note for its
// programmed length minus an articulation gap, and stops on END, stop or timeout.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned GAP_TICKS      = 1_250_000,
  parameter int unsigned FETCH_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic [NOTE_W-1:0]     note_out,
  output logic                  note_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W  = $clog2(8 * TICKS_PER_BEAT);
  localparam int unsigned TO_W   = $clog2(FETCH_TIMEOUT + 1);
  localparam int unsigned TW     = (CNT_W > TO_W) ? CNT_W : TO_W;
  localparam int unsigned PROD_W = CNT_W + 1;

  state_e            state;
  logic [NOTE_W-1:0] code;
  logic [DUR_W-1:0]  dur;
  logic [PROD_W-1:0] note_len;
  logic [PROD_W-1:0] sound_m1;
  logic              t_load;
  logic              t_dec;
  logic [TW-1:0]     t_val;
  logic              t_zero;

  assign code = mem_data[NOTE_MSB:NOTE_LSB];
  assign dur  = mem_data[DUR_MSB:DUR_LSB];

  // Sounding length minus one; one extra bit keeps (dur+1)*TICKS_PER_BEAT exact.
  assign note_len = (PROD_W'(dur) + PROD_W'(1)) * PROD_W'(TICKS_PER_BEAT);
  assign sound_m1 = note_len - PROD_W'(GAP_TICKS) - PROD_W'(1);

  // One timer serves the fetch timeout, the sounding time and the gap.
  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = '0;
    case (state)
      ST_FETCH: begin
        t_load = 1'b1;
        t_val  = TW'(FETCH_TIMEOUT - 1);
      end
      ST_WAIT: begin
        if (mem_ready) begin
          t_load = 1'b1;
          t_val  = TW'(sound_m1);
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_PLAY: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = TW'(GAP_TICKS - 1);
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_GAP:  t_dec = 1'b1;
      default: ;
    endcase
  end

  beat_timer #(
    .W(TW)
  ) u_beat_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      note_out     <= '0;
      note_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_read_rst <= 1'b0;
      done         <= 1'b0;
      // stop overrides everything, including a simultaneous start; err is kept.
      if (stop) begin
        state      <= ST_IDLE;
        note_out   <= '0;
        note_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state        <= ST_REWIND;
              mem_read_rst <= 1'b1;
              busy         <= 1'b1;
              err          <= 1'b0;
            end
          end
          ST_REWIND: begin
            state       <= ST_FETCH;
            mem_read_en <= 1'b1;
          end
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT: begin
            if (mem_ready) begin
              if (code == END_CODE) begin
                state <= ST_FINISH;
                done  <= 1'b1;
              end else begin
                state      <= ST_PLAY;
                note_out   <= code;
                note_valid <= (code != REST_CODE);
              end
            end else if (t_zero) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (t_zero) begin
              state      <= ST_GAP;
              note_out   <= '0;
              note_valid <= 1'b0;
            end
          end
          ST_GAP: begin
            if (t_zero) begin
              state       <= ST_FETCH;
              mem_read_en <= 1'b1;
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            note_out   <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a memory responder plus a per-cycle expected trace
// built from the song words and ready latencies.
module tb_note_sequencer;

  localparam int TPB = 4;
  localparam int GAP = 1;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       mem_read_en, mem_read_rst, note_valid, busy, done, err;
  logic [4:0] note_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  song[$];
  int          lat[$];
  logic [10:0] exp_q[$];
  int          rd_ptr = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  note_sequencer #(
    .TICKS_PER_BEAT (TPB),
    .GAP_TICKS      (GAP),
    .FETCH_TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .mem_read_en  (mem_read_en),
    .mem_read_rst (mem_read_rst),
    .note_out     (note_out),
    .note_valid   (note_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Memory: ready arrives lat[n] cycles after the fetch cycle (0 = never).
  always @(posedge clk) begin
    logic en_s, rs_s;
    en_s = mem_read_en;
    rs_s = mem_read_rst;
    #1;
    mem_ready = 1'b0;
    if (rs_s) rd_ptr = 0;
    if (en_s) wait_cnt = (rd_ptr < int'(lat.size())) ? lat[rd_ptr] : 1;
    if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        mem_ready = 1'b1;
        mem_data  = (rd_ptr < int'(song.size())) ? song[rd_ptr] : 8'hF8;
        rd_ptr++;
      end
    end
  end

  function automatic logic [10:0] pack(input bit r, input bit e, input bit b,
                                       input bit d, input bit v,
                                       input logic [4:0] n, input bit er);
    return {r, e, b, d, v, n, er};
  endfunction

  // Expected outputs for every cycle after start is accepted.
  task automatic build_trace();
    int         idx, l, s;
    bit         fin, e_err;
    logic [7:0] w;
    logic [4:0] c;
    int         d;
    exp_q.delete();
    e_err = 1'b0;
    exp_q.push_back(pack(1, 0, 1, 0, 0, 5'd0, 0));
    exp_q.push_back(pack(0, 1, 1, 0, 0, 5'd0, 0));
    idx = 0;
    fin = 1'b0;
    while (!fin) begin
      l = (idx < int'(lat.size())) ? lat[idx] : 1;
      if (l == 0 || l > TO) begin
        repeat (TO) exp_q.push_back(pack(0, 0, 1, 0, 0, 5'd0, 0));
        e_err = 1'b1;
        fin = 1'b1;
      end else begin
        repeat (l) exp_q.push_back(pack(0, 0, 1, 0, 0, 5'd0, 0));
        w = (idx < int'(song.size())) ? song[idx] : 8'hF8;
        c = w[7:3];
        d = int'(w[2:0]);
        if (c == 5'd31) begin
          exp_q.push_back(pack(0, 0, 1, 1, 0, 5'd0, 0));
          fin = 1'b1;
        end else begin
          s = (d + 1) * TPB - GAP;
          repeat (s) exp_q.push_back(pack(0, 0, 1, 0, c != 5'd0, c, 0));
          repeat (GAP) exp_q.push_back(pack(0, 0, 1, 0, 0, 5'd0, 0));
          exp_q.push_back(pack(0, 1, 1, 0, 0, 5'd0, 0));
          idx++;
        end
      end
    end
    repeat (3) exp_q.push_back(pack(0, 0, 0, 0, 0, 5'd0, e_err));
  endtask

  // Plays the current song and compares every cycle; optional start pulse at cycle inj.
  task automatic run_song(input string name, input int inj);
    logic [10:0] obs;
    int n;
    build_trace();
    n = int'(exp_q.size());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == inj);
      obs = {mem_read_rst, mem_read_en, busy, done, note_valid, note_out, err};
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: rst,en,busy,done,valid,note,err got %b required %b",
                 name, i, obs, exp_q[i]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: outputs got %b required 0",
               {mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_idle: outputs got %b required 0",
               {mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err});
    end
  endtask

  task automatic test_single_note();
    song = '{8'h2A, 8'hF8};
    lat  = '{1, 1};
    run_song("single_note", -1);
  endtask

  task automatic test_rest();
    song = '{8'h01, 8'hF8};
    lat  = '{1, 1};
    run_song("rest", -1);
  endtask

  task automatic test_ready_latency();
    song = '{8'h4B, 8'h2A, 8'hF8};
    lat  = '{3, 2, 4};
    run_song("ready_latency", -1);
  endtask

  task automatic test_timeout();
    song = '{8'h2A};
    lat  = '{0};
    run_song("timeout", -1);
    // stop and start together while idle: stop wins, err is kept
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, mem_read_rst, err} !== 3'b001) begin
      errors++;
      $display("FAIL stop_start_same: busy,rst,err got %b required 001",
               {busy, mem_read_rst, err});
    end
    song = '{8'h2A, 8'hF8};
    lat  = '{1, 1};
    run_song("err_cleared_by_start", -1);
  endtask

  task automatic test_stop_mid_note();
    bit bad;
    song = '{8'h3F, 8'hF8};
    lat  = '{1, 1};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({note_valid, note_out, busy} !== {1'b1, 5'd7, 1'b1}) begin
      errors++;
      $display("FAIL stop_pre_play: valid,note,busy got %b required %b",
               {note_valid, note_out, busy}, {1'b1, 5'd7, 1'b1});
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++;
    if ({note_valid, note_out, busy, done, err} !== 9'd0) begin
      errors++;
      $display("FAIL stop_next_edge: valid,note,busy,done,err got %b required 0",
               {note_valid, note_out, busy, done, err});
    end
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mem_read_en || done || busy || note_valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stop_quiet: activity seen after stop got 1 required 0");
    end
  endtask

  task automatic test_async_reset();
    song = '{8'h28, 8'hF8};
    lat  = '{1, 1};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, note_valid} !== 2'b10) begin
      errors++;
      $display("FAIL in_gap: busy,valid got %b required 10", {busy, note_valid});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: outputs got %b required 0",
               {mem_read_en, mem_read_rst, note_out, note_valid, busy, done, err});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_read_en, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL after_reset: en,busy,done got %b required 000",
               {mem_read_en, busy, done});
    end
  endtask

  task automatic test_start_while_busy();
    song = '{8'h3A, 8'hF8};
    lat  = '{1, 1};
    run_song("start_while_busy", 5);
  endtask

  task automatic test_random();
    int nw;
    for (int t = 0; t < 5; t++) begin
      song.delete();
      lat.delete();
      nw = int'($urandom_range(1, 4));
      for (int j = 0; j < nw; j++) begin
        song.push_back({5'($urandom_range(0, 30)), 3'($urandom_range(0, 2))});
        lat.push_back(int'($urandom_range(1, 4)));
      end
      song.push_back({5'd31, 3'($urandom_range(0, 7))});
      lat.push_back(int'($urandom_range(1, 3)));
      run_song($sformatf("random_%0d", t), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest();
    test_ready_latency();
    test_timeout();
    test_stop_mid_note();
    test_async_reset();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
